fifo_drain: RTL

Read-side controller for the team's synchronous FIFO: the consumer on the opposite port of the `wr_en`/`fifo_full` writer interface. It issues `fifo_rd_en` only while the FIFO is non-empty and space is guaranteed downstream. It absorbs the FIFO's 1-cycle read latency in a 2-entry output buffer and presents words on a valid/ready stream. It also counts delivered words for bench scoreboarding and for SVA checks.

---
 rtl/fifo_drain_pkg.sv | 15 +
 rtl/fifo_drain_buf.sv | 78 +++++++
 rtl/fifo_drain.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
//   buf_state_e : occupancy state of the 2-entry output buffer
//   BUF_DEPTH   : number of output buffer entries (read credit limit)
package fifo_drain_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  // Encoding equals occupancy so the state can be used directly as a count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_drain_buf.sv
// Two-entry ordered output buffer. Absorbs the FIFO read latency so reads can
// be issued ahead of downstream acceptance.
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data at the tail this edge
//   push_data   : word to write
//   pop         : head consumed this edge (ignored when empty)
//   head        : oldest buffered word
//   occ         : number of buffered words (0..2)
module fifo_drain_buf
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // Push without pop cannot happen here: the read credit forbids it.
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            state_d = BUF_ONE;
          end
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head = head_q;
  assign occ  = state_q;

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for the synchronous FIFO. Issues reads only while the
// FIFO is non-empty and buffer space is guaranteed, buffers the 1-cycle read
// latency and presents words on a valid/ready stream.
//   clk, rst     : clock, asynchronous active-high reset
//   drain_en     : permit new FIFO reads
//   fifo_empty   : FIFO empty flag
//   fifo_rd_data : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : FIFO read strobe
//   m_valid      : output word available
//   m_data       : output word
//   m_ready      : downstream accepts
//   drain_cnt    : words transferred on m_*, wrapping
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              drain_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  drain_cnt
);

  localparam logic [2:0] DepthLvl = 3'(BUF_DEPTH);

  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       level;

  fifo_drain_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;

  // Occupancy after this edge; pop implies occ >= 1 so this never underflows.
  // Including pop lets a read issue in the same cycle a full buffer drains.
  assign level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    fifo_rd_en = ~rst & drain_en & ~fifo_empty & (level < DepthLvl);
    inflight_d = fifo_rd_en;
    cnt_d      = pop ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign drain_cnt = cnt_q;

  a_rd_nonempty : assert property (@(posedge clk) disable iff (rst)
    fifo_rd_en |-> !fifo_empty);

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ} + {2'b00, inflight_q}) <= DepthLvl);

  a_data_stable : assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> ($stable(m_data) && m_valid));

  a_cnt_step : assert property (@(posedge clk) disable iff (rst)
    pop |=> (drain_cnt == $past(drain_cnt) + CNT_W'(1)));

endmodule
